// File: rtl/bp_cce_mmio_cfg_arbiter_if.sv
// Bundle of the requester-facing and network-facing handshake signals of the
// cfg/IO command arbiter.
//   master : the arbiter's view (consumes requester commands, issues to the
//            network, routes network responses back to requesters)
//   slave  : the environment's view (requesters plus the IO network link)
// Signals:
//   req_cmd_i        per-requester command, slice i = requester i
//   req_cmd_v_i      per-requester command valid
//   req_cmd_yumi_o   command accepted (one-hot or zero)
//   req_resp_o       response broadcast to all requesters
//   req_resp_v_o     response valid, one-hot to the owning requester
//   req_resp_ready_i per-requester response ready
//   io_cmd_o / io_cmd_v_o / io_cmd_yumi_i      command channel to network
//   io_resp_i / io_resp_v_i / io_resp_ready_o  response channel from network
interface bp_cce_mmio_cfg_arbiter_if #(
    parameter int num_req_p   = 2,
    parameter int msg_width_p = 128
);
    logic [num_req_p*msg_width_p-1:0] req_cmd_i;
    logic [num_req_p-1:0]             req_cmd_v_i;
    logic [num_req_p-1:0]             req_cmd_yumi_o;
    logic [msg_width_p-1:0]           req_resp_o;
    logic [num_req_p-1:0]             req_resp_v_o;
    logic [num_req_p-1:0]             req_resp_ready_i;
    logic [msg_width_p-1:0]           io_cmd_o;
    logic                             io_cmd_v_o;
    logic                             io_cmd_yumi_i;
    logic [msg_width_p-1:0]           io_resp_i;
    logic                             io_resp_v_i;
    logic                             io_resp_ready_o;

    modport master (
        input  req_cmd_i, req_cmd_v_i, req_resp_ready_i,
        input  io_cmd_yumi_i, io_resp_i, io_resp_v_i,
        output req_cmd_yumi_o, req_resp_o, req_resp_v_o,
        output io_cmd_o, io_cmd_v_o, io_resp_ready_o
    );

    modport slave (
        output req_cmd_i, req_cmd_v_i, req_resp_ready_i,
        output io_cmd_yumi_i, io_resp_i, io_resp_v_i,
        input  req_cmd_yumi_o, req_resp_o, req_resp_v_o,
        input  io_cmd_o, io_cmd_v_o, io_resp_ready_o
    );
endinterface

// File: rtl/bp_cce_mmio_cfg_arbiter.sv
// Shares one cfg/IO command channel among num_req_p requesters.
// Round-robin arbitration with a grant lock (a granted command stays on the
// channel until the network consumes it), an outstanding-command credit
// limit, and an in-order owner-ID FIFO that steers each network response back
// to the requester whose command it answers.
// Ports:
//   clk_i, reset_n_i  clock, asynchronous active-low reset
//   bus               handshake bundle (master modport)
//   credits_empty_o   no commands outstanding
//   grant_o           index of the requester currently driving io_cmd_o
//   err_o             sticky: a response arrived with nothing outstanding
module bp_cce_mmio_cfg_arbiter #(
    parameter int num_req_p     = 2,
    parameter int msg_width_p   = 128,
    parameter int max_credits_p = 8,
    localparam int lg_num_req_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    bp_cce_mmio_cfg_arbiter_if.master bus,
    output logic                     credits_empty_o,
    output logic [lg_num_req_lp-1:0] grant_o,
    output logic                     err_o
);
    localparam int cnt_w_lp = $clog2(max_credits_p + 1);
    localparam int ptr_w_lp = (max_credits_p > 1) ? $clog2(max_credits_p) : 1;
    localparam logic [num_req_p-1:0] one_lp = 1;

    typedef enum logic {IDLE, LOCK} state_e;

    state_e                   state_reg, state_next;
    logic [lg_num_req_lp-1:0] rr_ptr_reg, rr_ptr_next;
    logic [lg_num_req_lp-1:0] lock_idx_reg, lock_idx_next;
    logic [cnt_w_lp-1:0]      count_reg;
    logic [ptr_w_lp-1:0]      wr_ptr_reg, rd_ptr_reg;
    logic                     err_reg;
    logic [lg_num_req_lp-1:0] fifo_mem [max_credits_p];

    logic [lg_num_req_lp-1:0] cand_idx [num_req_p];
    logic [num_req_p-1:0]     cand_v;
    logic [msg_width_p-1:0]   cmd_slice [num_req_p];
    logic                     found;
    logic [lg_num_req_lp-1:0] winner;
    logic [lg_num_req_lp-1:0] grant_idx;
    logic [lg_num_req_lp-1:0] head;
    logic                     cmd_v, cmd_v_gated, issue, pop;
    logic                     fifo_empty, credits_full, cmd_ok;

    // Candidate gi is the requester gi places after rr_ptr (with wrap), so
    // the lowest set candidate is the round-robin winner.
    for (genvar gi = 0; gi < num_req_p; gi++) begin : g_cand
        logic [lg_num_req_lp:0] sum;
        assign sum = {1'b0, rr_ptr_reg} + (lg_num_req_lp+1)'(gi);
        assign cand_idx[gi] = (sum >= (lg_num_req_lp+1)'(num_req_p))
                            ? lg_num_req_lp'(sum - (lg_num_req_lp+1)'(num_req_p))
                            : lg_num_req_lp'(sum);
        assign cand_v[gi]    = bus.req_cmd_v_i[cand_idx[gi]];
        assign cmd_slice[gi] = bus.req_cmd_i[gi*msg_width_p +: msg_width_p];
    end

    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int i = num_req_p - 1; i >= 0; i--) begin
            if (cand_v[i]) begin
                found  = 1'b1;
                winner = cand_idx[i];
            end
        end
    end

    assign fifo_empty   = (count_reg == '0);
    assign credits_full = (count_reg == cnt_w_lp'(max_credits_p));
    assign head         = fifo_mem[rd_ptr_reg];
    assign pop          = bus.io_resp_v_i && !fifo_empty && bus.req_resp_ready_i[head];
    // A response retired in this same cycle frees a slot, so a full channel
    // may still accept a new command then; the FIFO pushes and pops together.
    assign cmd_ok       = !credits_full || pop;

    always_comb begin
        state_next    = state_reg;
        lock_idx_next = lock_idx_reg;
        cmd_v         = 1'b0;
        grant_idx     = '0;
        case (state_reg)
            IDLE: begin
                if (found && cmd_ok) begin
                    cmd_v     = 1'b1;
                    grant_idx = winner;
                    if (!bus.io_cmd_yumi_i) begin
                        state_next    = LOCK;
                        lock_idx_next = winner;
                    end
                end
            end
            LOCK: begin
                // Credit count cannot rise while locked, so no full check here.
                cmd_v     = 1'b1;
                grant_idx = lock_idx_reg;
                if (bus.io_cmd_yumi_i) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Reset must silence the command channel combinationally, not at an edge.
    assign cmd_v_gated = cmd_v && reset_n_i;
    assign issue       = cmd_v_gated && bus.io_cmd_yumi_i;

    always_comb begin
        rr_ptr_next = rr_ptr_reg;
        if (issue) begin
            rr_ptr_next = (grant_idx == lg_num_req_lp'(num_req_p - 1))
                        ? '0 : grant_idx + 1'b1;
        end
    end

    assign bus.io_cmd_o        = cmd_slice[grant_idx];
    assign bus.io_cmd_v_o      = cmd_v_gated;
    assign bus.req_cmd_yumi_o  = issue ? (one_lp << grant_idx) : '0;
    assign bus.req_resp_o      = bus.io_resp_i;
    assign bus.req_resp_v_o    = (bus.io_resp_v_i && !fifo_empty) ? (one_lp << head) : '0;
    // Unsolicited responses are always accepted so they can be dropped.
    assign bus.io_resp_ready_o = fifo_empty ? 1'b1 : bus.req_resp_ready_i[head];
    assign credits_empty_o     = fifo_empty;
    assign grant_o             = cmd_v_gated ? grant_idx : '0;
    assign err_o               = err_reg;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_reg    <= IDLE;
            rr_ptr_reg   <= '0;
            lock_idx_reg <= '0;
            count_reg    <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            rr_ptr_reg   <= rr_ptr_next;
            lock_idx_reg <= lock_idx_next;
            case ({issue, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
            if (issue) begin
                wr_ptr_reg <= (wr_ptr_reg == ptr_w_lp'(max_credits_p - 1)) ? '0 : wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= (rd_ptr_reg == ptr_w_lp'(max_credits_p - 1)) ? '0 : rd_ptr_reg + 1'b1;
            end
            if (bus.io_resp_v_i && fifo_empty) begin
                err_reg <= 1'b1;
            end
        end
    end

    // Owner-ID storage needs no reset: occupancy is tracked by count_reg.
    always_ff @(posedge clk_i) begin
        if (issue) begin
            fifo_mem[wr_ptr_reg] <= grant_idx;
        end
    end
endmodule

// File: doc/bp_cce_mmio_cfg_arbiter.md
Name: bp_cce_mmio_cfg_arbiter

Overview:
- Shares one config/IO command channel (cce_mem_msg) among num_req_p requesters, e.g. the cfg loader, a host debug port and a PC/IRF poker.
- Round-robin arbitration with grant lock, plus an outstanding-credit limiter.
- An in-order ID FIFO routes each response back to the requester that issued the matching command.
- Sits between the requesters and the IO NoC link to the tile cfg network.

Parameters:
- num_req_p, 2, number of requesters (2..8).
- msg_width_p, 128, width of a cce_mem_msg (header + data).
- max_credits_p, 8, maximum commands in flight on the IO channel; also the ID FIFO depth.
- lg_num_req_lp (local), `BSG_SAFE_CLOG2(num_req_p), width of a requester index.

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  asynchronous active-low reset
- req_cmd_i  in  num_req_p*msg_width_p  per-requester command, slice i = requester i
- req_cmd_v_i  in  num_req_p  per-requester command valid
- req_cmd_yumi_o  out  num_req_p  command accepted (one-hot or zero)
- req_resp_o  out  msg_width_p  response broadcast to all requesters
- req_resp_v_o  out  num_req_p  response valid, one-hot to the owning requester
- req_resp_ready_i  in  num_req_p  per-requester response ready
- io_cmd_o  out  msg_width_p  command to network
- io_cmd_v_o  out  1  command valid
- io_cmd_yumi_i  in  1  network consumed command
- io_resp_i  in  msg_width_p  response from network
- io_resp_v_i  in  1  response valid
- io_resp_ready_o  out  1  response ready
- credits_empty_o  out  1  no commands outstanding
- grant_o  out  lg_num_req_lp  index of the currently granted requester
- err_o  out  1  sticky: a response arrived with no outstanding command

Behaviour:
- Reset: asynchronous assert on reset_n_i low; synchronous release.
  - While in reset: state=IDLE, rr_ptr=0, credit count=0, FIFO empty, err_o=0.
  - Outputs during reset: io_cmd_v_o=0, all yumi_o=0, req_resp_v_o=0, io_resp_ready_o=1, credits_empty_o=1, grant_o=0.
- Reset mid-transaction: in-flight commands are forgotten. Any later response is an unsolicited response (see below).
- Arbiter FSM, IDLE:
  - Pick the first requester with valid set, searching from rr_ptr upward with wrap-around.
  - If one is found and credits are not full, go combinationally into the grant for this cycle: drive io_cmd_o = winner's slice, io_cmd_v_o=1, grant_o=winner.
  - If io_cmd_yumi_i is not asserted in that cycle, go to LOCK holding the winner.
- Arbiter FSM, LOCK:
  - io_cmd_o, io_cmd_v_o and grant_o stay on the locked requester until io_cmd_yumi_i.
  - A higher-priority arrival is ignored.
  - The requester must hold valid; no retraction is allowed.
  - Credits cannot become full while locked, because no command issues while locked.
- Handshake:
  - req_cmd_yumo_o[grant] = io_cmd_yumi_i. Yumi is same-cycle, with zero added latency.
  - On yumi: rr_ptr <= (winner+1) mod num_req_p; state <= IDLE; push winner index into the ID FIFO.
- Credits:
  - count +1 on io_cmd_yumi_i; -1 on (io_resp_v_i & io_resp_ready_o). A simultaneous inc and dec leaves count unchanged.
  - io_cmd_v_o is forced to 0 when count == max_credits_p. The count never exceeds max_credits_p.
  - credits_empty_o = (count == 0).
- Response routing:
  - If the FIFO is non-empty, head = owner. Then req_resp_o = io_resp_i, req_resp_v_o = io_resp_v_i << head, and io_resp_ready_o = req_resp_ready_i[head].
  - Pop the FIFO on the handshake.
  - Push and pop in the same cycle are both legal, including when the FIFO is full.
- Unsolicited response (FIFO empty):
  - io_resp_ready_o=1, the response is dropped, req_resp_v_o=0, the count stays 0, and err_o sets sticky until reset.
- Ordering: responses return in command order, a guarantee of the network. The block does no reordering.

Test Plan:
- Single requester 0 issues 3 commands with yumi each cycle -> 3 yumis, count goes 1,2,3; 3 responses are routed to req_resp_v_o=2'b01; credits_empty_o=1 at the end.
- Both requesters hold valid continuously with io_cmd_yumi_i=1 every cycle -> grants alternate 0,1,0,1 and each requester gets exactly 4 of 8 issues.
- Requester 0 is granted with yumi held low 5 cycles while requester 1 asserts valid -> grant_o stays 0 for all 5 cycles, io_cmd_o is unchanged, and requester 1 issues next.
- max_credits_p=8 with no responses: 8 issues, then io_cmd_v_o=0. Then, in one cycle, a response arrives and a new command is accepted -> count stays 8 and the FIFO stays full with the correct owner order.
- Interleaved issues from 0,1,1,0 -> the responses are delivered one-hot 01,10,10,01. Holding req_resp_ready_i[1]=0 stalls io_resp_ready_o=0 with no drop.
- io_resp_v_i with nothing outstanding -> response dropped, err_o=1 until reset. Assert reset_n_i low with 3 outstanding -> count=0 and io_cmd_v_o=0 immediately, without waiting for a clock edge.
